linear_layer_start_fifo_ctrl: RTL and testbench

- Control half of the start-propagation FIFO between Linear_Layer dataflow processes (e.g. the start token for the PE_i4xi4_pack units).
- Drives an external SRL shift-register array through its write-enable and read address. Shift semantics: the newest entry is at index 0 and the oldest at index count-1.
- Presents a first-word-fall-through FIFO interface to the producer and consumer, plus occupancy and sticky error status.

---
 rtl/linear_layer_start_fifo_ctrl.sv | 80 ++++++++
 tb/tb_linear_layer_start_fifo_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/linear_layer_start_fifo_ctrl.sv
// Control logic for the start-token FIFO: steers an external SRL shift array
// and presents a first-word-fall-through interface with occupancy and sticky errors.
module linear_layer_start_fifo_ctrl #(
  parameter int DATA_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 1,
  parameter int DEPTH        = 2,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  srl_we,
  output logic [ADDR_WIDTH-1:0] srl_addr,
  output logic [DATA_WIDTH-1:0] srl_din,
  input  logic [DATA_WIDTH-1:0] srl_dout,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam logic [ADDR_WIDTH:0] OCC_ZERO  = '0;
  localparam logic [ADDR_WIDTH:0] OCC_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] OCC_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] OCC_AFULL = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = (ADDR_WIDTH)'(1);

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH:0]   occ_next;
  logic [ADDR_WIDTH-1:0] addr_next;

  assign push    = if_write_ce & if_write & if_full_n;
  assign pop     = if_read_ce & if_read & if_empty_n;
  assign srl_we  = push;
  assign srl_din = if_din;
  assign if_dout = srl_dout;

  // The read address follows occupancy-1, saturating at 0 for the
  // empty and single-entry cases; a simultaneous push/pop leaves it alone.
  always_comb begin
    occ_next  = occupancy;
    addr_next = srl_addr;
    if (push && !pop) begin
      occ_next = occupancy + OCC_ONE;
      if (occupancy != OCC_ZERO) addr_next = srl_addr + ADDR_ONE;
    end else if (pop && !push) begin
      occ_next = occupancy - OCC_ONE;
      if (occupancy > OCC_ONE) addr_next = srl_addr - ADDR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy      <= '0;
      srl_addr       <= '0;
      if_empty_n     <= 1'b0;
      if_full_n      <= 1'b1;
      if_almost_full <= 1'b0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      occupancy      <= occ_next;
      srl_addr       <= addr_next;
      if_empty_n     <= (occ_next != OCC_ZERO);
      if_full_n      <= (occ_next != OCC_FULL);
      if_almost_full <= (occ_next >= OCC_AFULL);
      err_overflow   <= err_overflow  | (if_write_ce & if_write & ~if_full_n);
      err_underflow  <= err_underflow | (if_read_ce & if_read & ~if_empty_n);
    end
  end

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// Bench for linear_layer_start_fifo_ctrl: directed vector table plus random
// traffic against a queue-based FIFO model; the SRL array is modelled here.
module tb_linear_layer_start_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DP = 4;
  localparam int AF = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_write_ce = 1'b0, if_write = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n, if_almost_full;
  logic          if_read_ce = 1'b0, if_read = 1'b0;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic          srl_we;
  logic [AW-1:0] srl_addr;
  logic [DW-1:0] srl_din, srl_dout;
  logic [AW:0]   occupancy;
  logic          err_overflow, err_underflow;

  always #5 clk = ~clk;

  linear_layer_start_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .AFULL_THRESH(AF)
  ) dut (
    .clk(clk), .reset(reset),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_full_n(if_full_n), .if_almost_full(if_almost_full),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
    .if_empty_n(if_empty_n), .srl_we(srl_we), .srl_addr(srl_addr),
    .srl_din(srl_din), .srl_dout(srl_dout), .occupancy(occupancy),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  // External shift-register array: newest entry at index 0
  logic [DW-1:0] srl_mem [DP];
  always @(posedge clk) begin
    if (srl_we) begin
      for (int i = DP - 1; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
      srl_mem[0] <= srl_din;
    end
  end
  assign srl_dout = srl_mem[srl_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wce, input logic w,
                       input logic [DW-1:0] din, input logic rce, input logic r);
    @(negedge clk);
    reset = rst; if_write_ce = wce; if_write = w; if_din = din;
    if_read_ce = rce; if_read = r;
    #1;
  endtask

  typedef struct {
    logic rst, wce, w; logic [DW-1:0] din; logic rce, r;
    logic we; logic [AW:0] occ; logic en, fn, af; logic [AW-1:0] addr;
    logic [DW-1:0] dout; logic ovf, unf;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic rst, wce, w, input logic [DW-1:0] din, input logic rce, r,
                     input logic we, input logic [AW:0] occ, input logic en, fn, af,
                     input logic [AW-1:0] addr, input logic [DW-1:0] dout, input logic ovf, unf);
    vec_t v;
    v.rst = rst; v.wce = wce; v.w = w; v.din = din; v.rce = rce; v.r = r;
    v.we = we; v.occ = occ; v.en = en; v.fn = fn; v.af = af; v.addr = addr;
    v.dout = dout; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  // Reference model state
  logic [DW-1:0] q[$];
  logic m_ovf, m_unf;

  initial begin
    //  rst wce w din    rce r  we occ en fn af addr dout  ovf unf
    add(1, 0, 0, 8'h00, 0, 0,  0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 0, 1,  0, 0, 0, 1, 0, 0, 8'h00, 0, 0); // read with ce=0
    add(0, 1, 1, 8'hA1, 0, 0,  1, 1, 1, 1, 0, 0, 8'hA1, 0, 0);
    add(0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 1, 8'h01, 0, 0,  1, 1, 1, 1, 0, 0, 8'h01, 0, 0);
    add(0, 1, 1, 8'h02, 0, 0,  1, 2, 1, 1, 0, 1, 8'h01, 0, 0);
    add(0, 1, 1, 8'h03, 0, 0,  1, 3, 1, 1, 1, 2, 8'h01, 0, 0);
    add(0, 1, 1, 8'h04, 0, 0,  1, 4, 1, 0, 1, 3, 8'h01, 0, 0);
    add(0, 1, 1, 8'hFF, 0, 0,  0, 4, 1, 0, 1, 3, 8'h01, 1, 0); // write while full
    add(0, 0, 0, 8'h00, 0, 0,  0, 4, 1, 0, 1, 3, 8'h01, 1, 0);
    add(0, 1, 1, 8'hEE, 1, 1,  0, 3, 1, 1, 1, 2, 8'h02, 1, 0); // full: pop alone
    add(0, 0, 0, 8'h00, 1, 1,  0, 2, 1, 1, 0, 1, 8'h03, 1, 0);
    add(0, 0, 0, 8'h00, 1, 1,  0, 1, 1, 1, 0, 0, 8'h04, 1, 0);
    add(0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 1, 0, 0, 8'h00, 1, 0);
    add(0, 1, 1, 8'h10, 0, 0,  1, 1, 1, 1, 0, 0, 8'h10, 1, 0);
    add(0, 1, 1, 8'h20, 0, 0,  1, 2, 1, 1, 0, 1, 8'h10, 1, 0);
    add(0, 1, 1, 8'h30, 1, 1,  1, 2, 1, 1, 0, 1, 8'h20, 1, 0); // push+pop
    add(0, 0, 0, 8'h00, 1, 1,  0, 1, 1, 1, 0, 0, 8'h30, 1, 0);
    add(0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 1, 0, 0, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 1, 0, 0, 8'h00, 1, 1); // read while empty
    add(0, 0, 1, 8'h77, 0, 0,  0, 0, 0, 1, 0, 0, 8'h00, 1, 1); // write with ce=0
    add(0, 1, 1, 8'h55, 1, 1,  1, 1, 1, 1, 0, 0, 8'h55, 1, 1); // empty: push alone
    add(0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 1, 0, 0, 8'h00, 1, 1);
    add(0, 1, 1, 8'h61, 0, 0,  1, 1, 1, 1, 0, 0, 8'h61, 1, 1);
    add(0, 1, 1, 8'h62, 0, 0,  1, 2, 1, 1, 0, 1, 8'h61, 1, 1);
    add(0, 1, 1, 8'h63, 0, 0,  1, 3, 1, 1, 1, 2, 8'h61, 1, 1);
    add(1, 1, 1, 8'h64, 0, 0,  1, 0, 0, 1, 0, 0, 8'h00, 0, 0); // reset wins over push
    add(0, 0, 0, 8'h00, 0, 0,  0, 0, 0, 1, 0, 0, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.wce, v.w, v.din, v.rce, v.r);
      chk($sformatf("vec%0d srl_we", i), 32'(srl_we), 32'(v.we));
      @(posedge clk); #1;
      $display("vec %0d: rst=%0b w=%0b din=%02h r=%0b -> occ=%0d addr=%0d en=%0b fn=%0b af=%0b dout=%02h ovf=%0b unf=%0b",
               i, v.rst, v.wce & v.w, v.din, v.rce & v.r, occupancy, srl_addr,
               if_empty_n, if_full_n, if_almost_full, if_dout, err_overflow, err_underflow);
      chk($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(v.occ));
      chk($sformatf("vec%0d empty_n", i), 32'(if_empty_n), 32'(v.en));
      chk($sformatf("vec%0d full_n", i), 32'(if_full_n), 32'(v.fn));
      chk($sformatf("vec%0d almost_full", i), 32'(if_almost_full), 32'(v.af));
      chk($sformatf("vec%0d srl_addr", i), 32'(srl_addr), 32'(v.addr));
      if (v.en) chk($sformatf("vec%0d dout", i), 32'(if_dout), 32'(v.dout));
      chk($sformatf("vec%0d err_overflow", i), 32'(err_overflow), 32'(v.ovf));
      chk($sformatf("vec%0d err_underflow", i), 32'(err_underflow), 32'(v.unf));
    end

    // Random traffic against a queue model of the FIFO
    for (int t = 0; t < 500; t++) begin
      logic rst, wce, w, rce, r, e_push, e_pop;
      logic [DW-1:0] din;
      int sz;
      rst = (t == 0) || ($urandom_range(0, 59) == 0);
      wce = ($urandom_range(0, 7) != 0);
      w   = $urandom_range(0, 1);
      rce = ($urandom_range(0, 7) != 0);
      r   = $urandom_range(0, 1);
      din = DW'($urandom);
      drive(rst, wce, w, din, rce, r);
      e_push = wce && w && (q.size() < DP);
      e_pop  = rce && r && (q.size() > 0);
      chk($sformatf("rnd%0d srl_we", t), 32'(srl_we), 32'(e_push));
      if (rst) begin
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
        if (wce && w && q.size() == DP) m_ovf = 1'b1;
        if (rce && r && q.size() == 0) m_unf = 1'b1;
        if (e_pop) void'(q.pop_front());
        if (e_push) q.push_back(din);
      end
      @(posedge clk); #1;
      sz = q.size();
      $display("rnd %0d: rst=%0b push=%0b pop=%0b din=%02h -> occ=%0d dout=%02h ovf=%0b unf=%0b",
               t, rst, e_push, e_pop, din, occupancy, if_dout, err_overflow, err_underflow);
      chk($sformatf("rnd%0d occupancy", t), 32'(occupancy), 32'(sz));
      chk($sformatf("rnd%0d empty_n", t), 32'(if_empty_n), 32'(sz != 0));
      chk($sformatf("rnd%0d full_n", t), 32'(if_full_n), 32'(sz != DP));
      chk($sformatf("rnd%0d almost_full", t), 32'(if_almost_full), 32'(sz >= AF));
      chk($sformatf("rnd%0d srl_addr", t), 32'(srl_addr), 32'((sz == 0) ? 0 : sz - 1));
      if (sz != 0) chk($sformatf("rnd%0d dout", t), 32'(if_dout), 32'(q[0]));
      chk($sformatf("rnd%0d err_overflow", t), 32'(err_overflow), 32'(m_ovf));
      chk($sformatf("rnd%0d err_underflow", t), 32'(err_underflow), 32'(m_unf));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
